usb_fs_rx: RTL and testbench

- Device-side USB 2.0 FS receive front end.
- Consumes the raw dp/dn lines driven by the host model through usb_fe_if. Recovers bit timing by oversampling, detects SYNC, NRZI-decodes, removes stuffed bits, assembles bytes LSB-first and detects EOP.
- Feeds the packet decoder with a byte stream plus framing and error strobes.

---
 rtl/usb_fs_rx.sv | 180 ++++++++++++++++++
 tb/tb_usb_fs_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_rx.sv
// USB 2.0 full-speed receive front end: oversampled bit recovery, SYNC hunt, NRZI decode,
// bit unstuffing, LSB-first byte assembly and EOP detection. Define USB_FS_RX_DPLL_EN to track edges mid-packet.
module usb_fs_rx #(
    parameter int OVS       = 4,
    parameter int SAMPLE_PH = 2,
    parameter int SYNC_TMO  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp,
    input  logic       dn,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_err,
    output logic [1:0] line_state
);

    localparam int PW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int TW = $clog2(SYNC_TMO + 1);

    // Line states are packed as {dn, dp}.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

    state_t          state;
    logic [1:0]      meta, sync_line, line_d, prev;
    logic [PW-1:0]   phase, phase_cur;
    logic            reload, tick, dec;
    logic [TW-1:0]   sync_cnt;
    logic [2:0]      ones, bit_cnt;
    logic [1:0]      run_cnt;
    logic            misalign;
    logic [7:0]      shreg;

    // NOTE: synchronizer flops reset to J so an idle bus shows no spurious edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= LS_J;
            sync_line <= LS_J;
            line_d    <= LS_J;
        end else begin
            meta      <= {dn, dp};
            sync_line <= meta;
            line_d    <= sync_line;
        end
    end

    assign line_state = sync_line;

`ifdef USB_FS_RX_DPLL_EN
    assign reload = (sync_line != line_d);
`else
    // Only the idle-to-K edge that opens a packet sets the phase; it then free-runs.
    assign reload = (sync_line != line_d) && (state == IDLE);
`endif

    assign phase_cur = reload ? '0 : phase;
    assign tick      = (phase_cur == PW'(SAMPLE_PH));
    assign dec       = (sync_line == prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= (phase_cur == PW'(OVS - 1)) ? '0 : phase_cur + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev      <= LS_J;
            sync_cnt  <= '0;
            ones      <= '0;
            bit_cnt   <= '0;
            run_cnt   <= '0;
            misalign  <= 1'b0;
            shreg     <= '0;
            rx_active <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_eop    <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_err   <= 1'b0;
            if (tick) begin
                prev <= sync_line;
                case (state)
                    IDLE: begin
                        if (sync_line == LS_K) begin
                            state    <= SYNC;
                            sync_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    SYNC: begin
                        if (sync_line == LS_SE0) begin
                            state <= IDLE;
                        end else if (sync_line == LS_K && prev == LS_K) begin
                            state     <= DATA;
                            rx_active <= 1'b1;
                            ones      <= '0;
                            bit_cnt   <= '0;
                        end else if (sync_cnt == TW'(SYNC_TMO - 1)) begin
                            state <= IDLE;
                        end else begin
                            sync_cnt <= sync_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sync_line == LS_SE0) begin
                            state    <= EOP;
                            misalign <= (bit_cnt != 3'd0);
                            run_cnt  <= 2'd1;
                        end else if (sync_line == LS_SE1) begin
                            state     <= ABORT;
                            run_cnt   <= '0;
                            rx_active <= 1'b0;
                            rx_err    <= 1'b1;
                        end else if (ones == 3'd6) begin
                            // Bit following six ones must be a stuffed zero.
                            if (dec) begin
                                state     <= ABORT;
                                run_cnt   <= '0;
                                rx_active <= 1'b0;
                                rx_err    <= 1'b1;
                            end else begin
                                ones <= '0;
                            end
                        end else begin
                            ones    <= dec ? ones + 1'b1 : 3'd0;
                            shreg   <= {dec, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {dec, shreg[7:1]};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    EOP: begin
                        if (sync_line == LS_J) begin
                            state     <= IDLE;
                            rx_active <= 1'b0;
                            rx_eop    <= !misalign;
                            rx_err    <= misalign;
                        end else if (sync_line == LS_SE0 && run_cnt != 2'd2) begin
                            run_cnt <= run_cnt + 1'b1;
                        end else begin
                            state     <= ABORT;
                            run_cnt   <= '0;
                            rx_active <= 1'b0;
                            rx_err    <= 1'b1;
                        end
                    end
                    ABORT: begin
                        if (sync_line == LS_J) begin
                            if (run_cnt == 2'd1) begin
                                state <= IDLE;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_rx.sv
// Self-checking bench for usb_fs_rx: a host model NRZI-encodes and bit-stuffs packets onto dp/dn,
// expected bytes go into a scoreboard queue and are compared as rx_valid strobes appear.
`timescale 1ps/1ps
module tb_usb_fs_rx;

    localparam int CLK_HALF = 10417;
    localparam int BIT_PS   = 8 * CLK_HALF;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dp = 1'b1;
    logic       dn = 1'b0;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_err;
    logic [1:0] line_state;

    usb_fs_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dp        (dp),
        .dn        (dn),
        .rx_active (rx_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_eop    (rx_eop),
        .rx_err    (rx_err),
        .line_state(line_state)
    );

    always #CLK_HALF clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         cnt_valid, cnt_eop, cnt_err;
    bit         saw_active;
    logic [1:0] syms[$];
    logic [1:0] cur;
    int         ones;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_line(input logic [1:0] s);
        dn = s[1];
        dp = s[0];
    endtask

    task automatic start_pkt();
        syms.delete();
        for (int i = 0; i < 8; i++) syms.push_back((i % 2 == 0 || i == 7) ? K : J);
        cur  = K;
        ones = 0;
    endtask

    task automatic add_bit(input logic b, input bit stuff);
        if (!b) cur = (cur == K) ? J : K;
        syms.push_back(cur);
        ones = b ? ones + 1 : 0;
        if (stuff && ones == 6) begin
            cur = (cur == K) ? J : K;
            syms.push_back(cur);
            ones = 0;
        end
    endtask

    task automatic add_byte(input logic [7:0] v, input bit expect_it);
        for (int i = 0; i < 8; i++) add_bit(v[i], 1'b1);
        if (expect_it) exp_q.push_back(v);
    endtask

    task automatic add_eop();
        syms.push_back(SE0);
        syms.push_back(SE0);
        syms.push_back(J);
    endtask

    task automatic play(input int from, input int to, input int period, input int jit);
        int d;
        @(posedge clk);
        #5000;
        for (int i = from; i < to; i++) begin
            drive_line(syms[i]);
            d = period;
            if (jit > 0) d = period + int'($urandom_range(2 * jit)) - jit;
            #(d);
        end
    endtask

    task automatic idle(input int nbits);
        drive_line(J);
        for (int i = 0; i < nbits; i++) #(BIT_PS);
    endtask

    task automatic clear_counts();
        cnt_valid  = 0;
        cnt_eop    = 0;
        cnt_err    = 0;
        saw_active = 1'b0;
    endtask

    task automatic end_checks(input string name, input int valid_e, input int eop_e, input int err_e);
        check({name, "_valid_cnt"}, 32'(cnt_valid), 32'(valid_e));
        check({name, "_eop_cnt"}, 32'(cnt_eop), 32'(eop_e));
        check({name, "_err_cnt"}, 32'(cnt_err), 32'(err_e));
        check({name, "_queue_left"}, 32'(exp_q.size()), 0);
        check({name, "_active_end"}, 32'(rx_active), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                cnt_valid++;
                if (exp_q.size() == 0) check("spurious_valid", 32'(rx_valid), 0);
                else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (rx_eop) cnt_eop++;
            if (rx_err) cnt_err++;
            if (rx_eop && rx_err) check("eop_err_together", 32'(rx_err), 0);
            if (rx_active) saw_active = 1'b1;
        end
    end

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_line(J);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_active", 32'(rx_active), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_eop", 32'(rx_eop), 0);
        check("rst_err", 32'(rx_err), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_line_state", 32'(line_state), 32'(J));
        rst_n = 1'b1;
        idle(4);
        check("idle_line_state", 32'(line_state), 32'(J));

        // Basic three-byte packet
        clear_counts();
        start_pkt();
        add_byte(8'h69, 1'b1);
        add_byte(8'h00, 1'b1);
        add_byte(8'h10, 1'b1);
        add_eop();
        play(0, syms.size(), BIT_PS, 0);
        idle(4);
        check("basic_saw_active", 32'(saw_active), 1);
        end_checks("basic", 3, 1, 0);

        // Bit-stuffed all-ones payload
        clear_counts();
        start_pkt();
        add_byte(8'hFF, 1'b1);
        add_byte(8'hFF, 1'b1);
        add_eop();
        play(0, syms.size(), BIT_PS, 0);
        idle(4);
        end_checks("stuffed", 2, 1, 0);

        // Seven ones without the stuffed zero
        clear_counts();
        start_pkt();
        for (int i = 0; i < 8; i++) add_bit(i < 7, 1'b0);
        add_eop();
        play(0, syms.size(), BIT_PS, 0);
        idle(4);
        check("stufferr_saw_active", 32'(saw_active), 1);
        end_checks("stufferr", 0, 0, 1);

        // Recovery after stuff error
        clear_counts();
        start_pkt();
        add_byte(8'hA5, 1'b1);
        add_byte(8'h5A, 1'b1);
        add_eop();
        play(0, syms.size(), BIT_PS, 0);
        idle(4);
        end_checks("recover", 2, 1, 0);

        // Twelve data bits then EOP: one byte, then misaligned-EOP error
        clear_counts();
        start_pkt();
        add_byte(8'hC3, 1'b1);
        for (int i = 0; i < 4; i++) add_bit(i[0], 1'b1);
        add_eop();
        play(0, syms.size(), BIT_PS, 0);
        idle(4);
        end_checks("misalign", 1, 0, 1);

        // Lone K then idle: SYNC hunt must give up silently
        clear_counts();
        @(posedge clk);
        #5000;
        drive_line(K);
        #(BIT_PS * 3 / 4);
        check("line_state_k", 32'(line_state), 32'(K));
        #(BIT_PS / 4);
        idle(24);
        check("sync_tmo_active", 32'(saw_active), 0);
        end_checks("sync_tmo", 0, 0, 0);

        // Reset mid-packet after the second byte
        clear_counts();
        start_pkt();
        add_byte(8'h12, 1'b1);
        add_byte(8'h34, 1'b1);
        add_byte(8'h56, 1'b0);
        add_byte(8'h78, 1'b0);
        add_eop();
        play(0, 28, BIT_PS, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_active", 32'(rx_active), 0);
        check("midrst_valid", 32'(rx_valid), 0);
        check("midrst_eop", 32'(rx_eop), 0);
        check("midrst_err", 32'(rx_err), 0);
        check("midrst_data", 32'(rx_data), 0);
        check("midrst_line_state", 32'(line_state), 32'(J));
        play(28, syms.size(), BIT_PS, 0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        end_checks("midrst", 2, 0, 0);

        // Packet after reset
        clear_counts();
        start_pkt();
        add_byte(8'h3C, 1'b1);
        add_byte(8'hE1, 1'b1);
        add_eop();
        play(0, syms.size(), BIT_PS, 0);
        idle(4);
        end_checks("post_rst", 2, 1, 0);

`ifdef USB_FS_RX_DPLL_EN
        // 64 random bytes, 0.25% slow host with +-100 ps jitter
        clear_counts();
        start_pkt();
        for (int i = 0; i < 64; i++) add_byte(8'($urandom_range(255)), 1'b1);
        add_eop();
        play(0, syms.size(), 83541, 100);
        idle(4);
        end_checks("jitter", 64, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
